// File: rtl/bin_to_bcd_glyph_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_glyph_seq_if
// Brief    : Start/busy/done handshake and result bus of the BCD glyph sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_glyph_seq_if #(
  parameter int BIN_W   = 8,
  parameter int DIGITS  = 3,
  parameter int GLYPH_W = 6
);
  logic                        start;
  logic [BIN_W-1:0]            bin;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic [4*DIGITS-1:0]         bcd;
  logic [GLYPH_W*DIGITS-1:0]   glyphs;

  modport master (
    output start, bin,
    input  busy, done, overflow, bcd, glyphs
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, bcd, glyphs
  );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_glyph_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_glyph_seq
// Brief    : Bit-serial double-dabble converter mapping BCD digits to HUD glyphs,
//            with sticky overflow saturating the display to all nines.
//            Optional macro T03_LEAD_ZERO_BLANK_EN blanks leading zero digits.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_glyph_seq #(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int GLYPH_W     = 6,
  parameter int GLYPH_BASE  = 26,
  parameter int GLYPH_BLANK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bin_to_bcd_glyph_seq_if.slave bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int GV_W  = GLYPH_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [CNT_W-1:0]   C_CNT_LOAD   = CNT_W'(BIN_W - 1);
  localparam logic [GLYPH_W-1:0] C_GLYPH_BASE = GLYPH_W'(GLYPH_BASE);
  localparam logic [GLYPH_W-1:0] C_GLYPH_SAT  = GLYPH_W'(GLYPH_BASE + 9);
`ifdef T03_LEAD_ZERO_BLANK_EN
  localparam logic [GLYPH_W-1:0] C_GLYPH_BLK  = GLYPH_W'(GLYPH_BLANK);
`endif

  function automatic logic [GV_W-1:0] f_glyph_rst();
    logic [GV_W-1:0] v;
    v = '0;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef T03_LEAD_ZERO_BLANK_EN
      v[k*GLYPH_W +: GLYPH_W] = (k == 0) ? C_GLYPH_BASE : C_GLYPH_BLK;
`else
      v[k*GLYPH_W +: GLYPH_W] = C_GLYPH_BASE;
`endif
    end
    return v;
  endfunction

  localparam logic [GV_W-1:0]  C_GLYPH_RST = f_glyph_rst();
  localparam logic [GV_W-1:0]  C_GLYPH_ALL9 = {DIGITS{C_GLYPH_SAT}};
  localparam logic [ACC_W-1:0] C_BCD_ALL9   = {DIGITS{4'h9}};

  // Elaboration-time sanity checks on the configuration
  if (BIN_W < 1 || DIGITS < 1) begin : g_chk_size
    $error("bin_to_bcd_glyph_seq: BIN_W and DIGITS must be >= 1");
  end
  if (GLYPH_BLANK < 0 || GLYPH_BLANK >= (1 << GLYPH_W) ||
      GLYPH_BASE < 0 || GLYPH_BASE + 9 >= (1 << GLYPH_W)) begin : g_chk_glyph
    $error("bin_to_bcd_glyph_seq: glyph indices do not fit in GLYPH_W");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_commit;

  logic [BIN_W-1:0]   r_shift;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic [ACC_W-1:0]   r_bcd;
  logic [GV_W-1:0]    r_glyphs;
  logic               r_overflow;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_next;
  logic [BIN_W-1:0]   w_shift_next;
  logic               w_ovf_final;
  logic [GV_W-1:0]    w_glyph_commit;
  logic [3:0]         w_digit;
`ifdef T03_LEAD_ZERO_BLANK_EN
  logic               w_lead;
`endif

  // Add-3 correction, nibble-local with 4-bit wrap
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                         : r_acc[4*k +: 4];
  end

  assign w_acc_next   = {w_adj[ACC_W-2:0], r_shift[BIN_W-1]};
  assign w_shift_next = r_shift << 1;
  // A 1 in the adjusted MSB is about to be shifted out: value exceeds the digits
  assign w_ovf_final  = r_ovf | w_adj[ACC_W-1];

  always_comb begin
    w_glyph_commit = '0;
    w_digit        = '0;
`ifdef T03_LEAD_ZERO_BLANK_EN
    w_lead         = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_digit = w_acc_next[4*k +: 4];
`ifdef T03_LEAD_ZERO_BLANK_EN
      if (k != 0 && w_lead && w_digit == 4'd0) begin
        w_glyph_commit[k*GLYPH_W +: GLYPH_W] = C_GLYPH_BLK;
      end else begin
        w_glyph_commit[k*GLYPH_W +: GLYPH_W] = C_GLYPH_BASE + GLYPH_W'(w_digit);
      end
      w_lead = w_lead && (w_digit == 4'd0);
`else
      w_glyph_commit[k*GLYPH_W +: GLYPH_W] = C_GLYPH_BASE + GLYPH_W'(w_digit);
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_commit     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_glyphs   <= C_GLYPH_RST;
      r_overflow <= 1'b0;
    end else if (w_load) begin
      r_shift <= bus.bin;
      r_acc   <= '0;
      r_cnt   <= C_CNT_LOAD;
      r_ovf   <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_acc   <= w_acc_next;
      r_shift <= w_shift_next;
      r_ovf   <= w_ovf_final;
      if (w_commit) begin
        r_overflow <= w_ovf_final;
        r_bcd      <= w_ovf_final ? C_BCD_ALL9   : w_acc_next;
        r_glyphs   <= w_ovf_final ? C_GLYPH_ALL9 : w_glyph_commit;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = (r_state == S_DONE);
  assign bus.overflow = r_overflow;
  assign bus.bcd      = r_bcd;
  assign bus.glyphs   = r_glyphs;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_glyph_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_glyph_seq
// Brief    : Directed self-checking bench; 3-digit and 2-digit instances run in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_glyph_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  bin_to_bcd_glyph_seq_if #(.BIN_W(8), .DIGITS(3), .GLYPH_W(6)) b3 ();
  bin_to_bcd_glyph_seq_if #(.BIN_W(8), .DIGITS(2), .GLYPH_W(6)) b2 ();

  bin_to_bcd_glyph_seq #(.BIN_W(8), .DIGITS(3), .GLYPH_W(6), .GLYPH_BASE(26), .GLYPH_BLANK(3))
    u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  bin_to_bcd_glyph_seq #(.BIN_W(8), .DIGITS(2), .GLYPH_W(6), .GLYPH_BASE(26), .GLYPH_BLANK(3))
    u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // One conversion on both instances; glyph expectations given without/with blanking
  task automatic conv(input logic [7:0] v3, input logic [11:0] e_bcd3,
                      input logic [17:0] e_gl3_nb, input logic [17:0] e_gl3_bl,
                      input logic [7:0] v2, input logic e_ovf2, input logic [7:0] e_bcd2,
                      input logic [11:0] e_gl2_nb, input logic [11:0] e_gl2_bl,
                      input bit poke);
    int busy_n;
    int done_at;
    logic [17:0] e_gl3;
    logic [11:0] e_gl2;
`ifdef T03_LEAD_ZERO_BLANK_EN
    e_gl3 = e_gl3_bl;
    e_gl2 = e_gl2_bl;
`else
    e_gl3 = e_gl3_nb;
    e_gl2 = e_gl2_nb;
`endif
    @(negedge clk);
    b3.start = 1'b1; b3.bin = v3;
    b2.start = 1'b1; b2.bin = v2;
    @(posedge clk); #1;
    b3.start = 1'b0; b3.bin = 8'hA5;
    b2.start = 1'b0; b2.bin = 8'h5A;
    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      if (poke && c == 3) begin b3.start = 1'b1; b3.bin = 8'd99; end
      if (poke && c == 4) b3.start = 1'b0;
      if (b3.busy) busy_n++;
      if (b3.done) begin done_at = c; break; end
      @(posedge clk); #1;
    end
    check("latency", done_at, 9);
    check("busy_cycles", busy_n, 8);
    check("bcd3", b3.bcd, e_bcd3);
    check("glyphs3", b3.glyphs, e_gl3);
    check("ovf3", b3.overflow, 1'b0);
    check("done2", b2.done, 1'b1);
    check("bcd2", b2.bcd, e_bcd2);
    check("glyphs2", b2.glyphs, e_gl2);
    check("ovf2", b2.overflow, e_ovf2);
    @(posedge clk); #1;
    check("done_pulse_len", b3.done, 1'b0);
    check("idle_busy", b3.busy, 1'b0);
    check("hold_bcd3", b3.bcd, e_bcd3);
  endtask

  int first_done;
  int second_done;
  int busy_cnt;
  int done_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    b3.start = 1'b0; b3.bin = '0;
    b2.start = 1'b0; b2.bin = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", b3.busy, 1'b0);
    check("rst_done", b3.done, 1'b0);
    check("rst_bcd", b3.bcd, 12'h000);
    check("rst_ovf", b3.overflow, 1'b0);
`ifdef T03_LEAD_ZERO_BLANK_EN
    check("rst_glyphs3", b3.glyphs, {6'd3, 6'd3, 6'd26});
    check("rst_glyphs2", b2.glyphs, {6'd3, 6'd26});
`else
    check("rst_glyphs3", b3.glyphs, {6'd26, 6'd26, 6'd26});
    check("rst_glyphs2", b2.glyphs, {6'd26, 6'd26});
`endif
    @(negedge clk) rst = 1'b0;

    conv(8'd15, 12'h015, {6'd26, 6'd27, 6'd31}, {6'd3, 6'd27, 6'd31},
         8'd200, 1'b1, 8'h99, {6'd35, 6'd35}, {6'd35, 6'd35}, 1'b0);
    conv(8'd255, 12'h255, {6'd28, 6'd31, 6'd31}, {6'd28, 6'd31, 6'd31},
         8'd42, 1'b0, 8'h42, {6'd30, 6'd28}, {6'd30, 6'd28}, 1'b0);
    conv(8'd0, 12'h000, {6'd26, 6'd26, 6'd26}, {6'd3, 6'd3, 6'd26},
         8'd0, 1'b0, 8'h00, {6'd26, 6'd26}, {6'd3, 6'd26}, 1'b0);
    // start during SHIFT must be ignored
    conv(8'd7, 12'h007, {6'd26, 6'd26, 6'd33}, {6'd3, 6'd3, 6'd33},
         8'd99, 1'b0, 8'h99, {6'd35, 6'd35}, {6'd35, 6'd35}, 1'b1);

    // Back-to-back: start held high, new bin presented in the DONE cycle
    @(negedge clk);
    b3.start = 1'b1; b3.bin = 8'd100;
    @(posedge clk); #1;
    first_done = 0; second_done = 0; busy_cnt = 0;
    for (int c = 1; c <= 24; c++) begin
      if (first_done != 0 && c == first_done + 1) b3.start = 1'b0;
      if (b3.busy) busy_cnt++;
      if (b3.done) begin
        check("b2b_busy_in_done", b3.busy, 1'b0);
        if (first_done == 0) begin
          first_done = c;
          check("b2b_bcd0", b3.bcd, 12'h100);
          check("b2b_glyphs0", b3.glyphs, {6'd27, 6'd26, 6'd26});
          b3.bin = 8'd9;
        end else begin
          second_done = c;
          check("b2b_bcd1", b3.bcd, 12'h009);
`ifdef T03_LEAD_ZERO_BLANK_EN
          check("b2b_glyphs1", b3.glyphs, {6'd3, 6'd3, 6'd35});
`else
          check("b2b_glyphs1", b3.glyphs, {6'd26, 6'd26, 6'd35});
`endif
        end
      end
      if (second_done != 0) break;
      @(posedge clk); #1;
    end
    b3.start = 1'b0;
    check("b2b_done0_cycle", first_done, 9);
    check("b2b_done1_cycle", second_done, 18);
    check("b2b_busy_cycles", busy_cnt, 16);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    b3.start = 1'b1; b3.bin = 8'd123;
    @(posedge clk); #1;
    b3.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", b3.busy, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_busy", b3.busy, 1'b0);
    check("arst_done", b3.done, 1'b0);
    check("arst_bcd3", b3.bcd, 12'h000);
    check("arst_bcd2", b2.bcd, 8'h00);
    check("arst_ovf2", b2.overflow, 1'b0);
`ifdef T03_LEAD_ZERO_BLANK_EN
    check("arst_glyphs3", b3.glyphs, {6'd3, 6'd3, 6'd26});
`else
    check("arst_glyphs3", b3.glyphs, {6'd26, 6'd26, 6'd26});
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b3.done) done_seen++;
    end
    check("arst_no_done", done_seen, 0);

    conv(8'd123, 12'h123, {6'd27, 6'd28, 6'd29}, {6'd27, 6'd28, 6'd29},
         8'd100, 1'b1, 8'h99, {6'd35, 6'd35}, {6'd35, 6'd35}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
